// File: rtl/spi_cmd_pkg.sv
// rtl/spi_cmd_pkg.sv - shared opcodes, decoder states and frame constants
package spi_cmd_pkg;

  localparam int FRAME_LEN = 32;
  localparam int CNT_W     = 6;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_FILL  = 8'h02;
  localparam logic [7:0] OP_SCORE = 8'h03;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FILL  = 2'd2
  } dec_state_e;

  function automatic logic is_known_op(input logic [7:0] op);
    return (op == OP_WRITE) || (op == OP_FILL) || (op == OP_SCORE);
  endfunction

endpackage

// File: rtl/spi_frame_rx.sv
// rtl/spi_frame_rx.sv - SPI sampling, 32-bit framing and abort detection
module spi_frame_rx
  import spi_cmd_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetB,
  input  logic                 cs,
  input  logic                 sck,
  input  logic                 sdi,
  output logic [FRAME_LEN-1:0] frame,
  output logic                 frame_valid,
  output logic                 abort
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  logic [1:0]           cs_sync_q, cs_sync_d;
  logic [1:0]           sck_sync_q, sck_sync_d;
  logic [1:0]           sdi_sync_q, sdi_sync_d;
  logic                 sck_prev_q, sck_prev_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [FRAME_LEN-1:0] shift_q, shift_d;
  logic [FRAME_LEN-1:0] frame_q, frame_d;
  logic                 frame_valid_q, frame_valid_d;
  logic                 abort_q, abort_d;

  logic cs_s, sck_s, sdi_s, sck_rise;

  assign cs_s     = cs_sync_q[1];
  assign sck_s    = sck_sync_q[1];
  assign sdi_s    = sdi_sync_q[1];
  assign sck_rise = sck_s & ~sck_prev_q;

  // Shift register, bit counter and abort/complete decisions for the next clk
  always_comb begin
    cs_sync_d     = {cs_sync_q[0], cs};
    sck_sync_d    = {sck_sync_q[0], sck};
    sdi_sync_d    = {sdi_sync_q[0], sdi};
    sck_prev_d    = sck_s;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    frame_d       = frame_q;
    frame_valid_d = 1'b0;
    abort_d       = 1'b0;
    if (!cs_s) begin
      // Counter clears while deselected, so a partial frame aborts exactly once.
      bit_cnt_d = '0;
      shift_d   = '0;
      abort_d   = (bit_cnt_q != '0) && (bit_cnt_q != CNT_FULL);
    end else if (sck_rise && (bit_cnt_q < CNT_FULL)) begin
      shift_d   = {shift_q[FRAME_LEN-2:0], sdi_s};
      bit_cnt_d = bit_cnt_q + 1'b1;
      if (bit_cnt_q == CNT_LAST) begin
        frame_valid_d = 1'b1;
        frame_d       = shift_d;
      end
    end
  end

  // Synchronizers and receive state
  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      cs_sync_q     <= '0;
      sck_sync_q    <= '0;
      sdi_sync_q    <= '0;
      sck_prev_q    <= 1'b0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      abort_q       <= 1'b0;
    end else begin
      cs_sync_q     <= cs_sync_d;
      sck_sync_q    <= sck_sync_d;
      sdi_sync_q    <= sdi_sync_d;
      sck_prev_q    <= sck_prev_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      abort_q       <= abort_d;
    end
  end

  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;
  assign abort       = abort_q;

endmodule

// File: rtl/spi_cmd_frontend.sv
// rtl/spi_cmd_frontend.sv - SPI command decoder driving framebuffer writes and score
module spi_cmd_frontend
  import spi_cmd_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 600,
  parameter int SCORE_W = 10
) (
  input  logic               clk,
  input  logic               resetB,
  input  logic               cs,
  input  logic               sck,
  input  logic               sdi,
  output logic               we,
  output logic [ADDR_W-1:0]  waddr,
  output logic [DATA_W-1:0]  wdata,
  output logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [FRAME_LEN-1:0] rx_frame;
  logic                 rx_valid, rx_abort;

  spi_frame_rx u_rx (
    .clk         (clk),
    .resetB      (resetB),
    .cs          (cs),
    .sck         (sck),
    .sdi         (sdi),
    .frame       (rx_frame),
    .frame_valid (rx_valid),
    .abort       (rx_abort)
  );

  dec_state_e           state_q, state_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [FRAME_LEN-1:0] pend_frame_q, pend_frame_d;
  logic [ADDR_W-1:0]    cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0]    cmd_data_q, cmd_data_d;
  logic [ADDR_W-1:0]    fill_cnt_q, fill_cnt_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    waddr_q, waddr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;

  logic       consume, drop;
  logic [7:0] pend_op;
  logic       unused_frame_bits;

  assign pend_op = pend_frame_q[31:24];
  assign consume = (state_q == ST_IDLE) && pend_valid_q;
  assign drop    = rx_valid && pend_valid_q && !consume;
  // Payload bits beyond the configured widths are intentionally discarded.
  assign unused_frame_bits = ^pend_frame_q;

  // Decoder state register
  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Decoder next-state: dispatch on the pending opcode, FILL runs to LAST_ADDR
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (consume) begin
          if (pend_op == OP_WRITE)     state_d = ST_WRITE;
          else if (pend_op == OP_FILL) state_d = ST_FILL;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_FILL:  if (fill_cnt_q == LAST_ADDR) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Pending slot, command capture and registered write/score/err outputs
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_frame_d = pend_frame_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_data_d   = cmd_data_q;
    fill_cnt_d   = fill_cnt_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    score_d      = score_q;
    busy_d       = 1'b0;
    err_d        = rx_abort | drop;

    // A frame arriving while the slot drains refills it in the same clk.
    if (consume) pend_valid_d = 1'b0;
    if (rx_valid && !drop) begin
      pend_valid_d = 1'b1;
      pend_frame_d = rx_frame;
    end

    if (consume) begin
      cmd_addr_d = pend_frame_q[ADDR_W+7:8];
      cmd_data_d = pend_frame_q[DATA_W-1:0];
      fill_cnt_d = '0;
      if (pend_op == OP_SCORE) score_d = pend_frame_q[SCORE_W+7:8];
      if (!is_known_op(pend_op)) err_d = 1'b1;
    end

    case (state_q)
      ST_WRITE: begin
        we_d    = 1'b1;
        waddr_d = cmd_addr_q;
        wdata_d = cmd_data_q;
      end
      ST_FILL: begin
        we_d    = 1'b1;
        waddr_d = fill_cnt_q;
        wdata_d = cmd_data_q;
        busy_d  = 1'b1;
        if (fill_cnt_q != LAST_ADDR) fill_cnt_d = fill_cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      pend_valid_q <= 1'b0;
      pend_frame_q <= '0;
      cmd_addr_q   <= '0;
      cmd_data_q   <= '0;
      fill_cnt_q   <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      score_q      <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_frame_q <= pend_frame_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_data_q   <= cmd_data_d;
      fill_cnt_q   <= fill_cnt_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      score_q      <= score_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign score = score_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_spi_cmd_frontend.sv
// tb/tb_spi_cmd_frontend.sv - scoreboard bench for spi_cmd_frontend
module tb_spi_cmd_frontend;

  typedef struct packed {
    logic [9:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       resetB = 1'b0;
  logic       cs = 1'b0;
  logic       sck = 1'b0;
  logic       sdi = 1'b0;
  logic       we;
  logic [9:0] waddr;
  logic [7:0] wdata;
  logic [9:0] score;
  logic       busy;
  logic       err;

  int  checks = 0;
  int  errors = 0;
  int  busy_cnt = 0;
  int  err_cnt = 0;
  wr_t exp_q[$];

  spi_cmd_frontend #(
    .ADDR_W  (10),
    .DATA_W  (8),
    .DEPTH   (600),
    .SCORE_W (10)
  ) dut (
    .clk    (clk),
    .resetB (resetB),
    .cs     (cs),
    .sck    (sck),
    .sdi    (sdi),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .score  (score),
    .busy   (busy),
    .err    (err)
  );

  always #5 clk = ~clk;

  // Monitor: pops the expected write whenever the DUT strobes we
  always @(negedge clk) begin
    if (resetB) begin
      if (busy) busy_cnt++;
      if (err) err_cnt++;
      if (we) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=%0h data=%0h, required no write", waddr, wdata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if ({waddr, wdata} !== e) begin
            errors++;
            $display("FAIL write: got addr=%0h data=%0h, required addr=%0h data=%0h", waddr, wdata, e.a, e.d);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic send_bits(input logic [31:0] f, input int n);
    cs = 1'b1;
    repeat (4) @(posedge clk);
    for (int i = 0; i < n; i++) begin
      sdi = f[31-i];
      #30 sck = 1'b1;
      #30 sck = 1'b0;
    end
    #30 cs = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic push_fill(input logic [7:0] d);
    for (int i = 0; i < 600; i++) exp_q.push_back('{a: 10'(i), d: d});
  endtask

  task automatic wait_drain(input string name, input int max);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < max) begin
      @(posedge clk);
      n++;
    end
    repeat (8) @(posedge clk);
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int n;

    repeat (3) @(posedge clk);
    #1;
    check("rst_we", we, 0);
    check("rst_busy", busy, 0);
    check("rst_score", score, 0);
    check("rst_waddr", waddr, 0);
    resetB = 1'b1;
    repeat (4) @(posedge clk);

    // Single WRITE
    exp_q.push_back('{a: 10'h12C, d: 8'h5A});
    send_bits(32'h01012C5A, 32);
    wait_drain("write_drain", 100);
    check("write_err", err_cnt, 0);

    // FILL of whole buffer, busy duration
    push_fill(8'h07);
    busy_cnt = 0;
    send_bits(32'h02000007, 32);
    wait_drain("fill_drain", 1000);
    check("fill_busy_cycles", busy_cnt, 600);

    // SCORE
    send_bits(32'h03002A00, 32);
    repeat (10) @(posedge clk);
    check("score_42", score, 42);

    // Aborted partial frame then WRITE
    e0 = err_cnt;
    send_bits(32'hFFF00000, 12);
    repeat (6) @(posedge clk);
    check("abort_err", err_cnt - e0, 1);
    exp_q.push_back('{a: 10'h005, d: 8'h33});
    send_bits(32'h01000533, 32);
    wait_drain("abort_write_drain", 100);
    check("abort_err_total", err_cnt - e0, 1);

    // Two WRITEs during FILL: first pends, second drops
    e0 = err_cnt;
    push_fill(8'h3C);
    exp_q.push_back('{a: 10'h001, d: 8'h11});
    send_bits(32'h0200003C, 32);
    n = 0;
    while (!busy && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("fill2_busy_rise", busy, 1);
    send_bits(32'h01000111, 32);
    send_bits(32'h01000222, 32);
    check("fill2_still_busy", busy, 1);
    wait_drain("fill2_drain", 1000);
    check("drop_err", err_cnt - e0, 1);

    // Unknown opcode
    e0 = err_cnt;
    send_bits(32'h7F123456, 32);
    repeat (10) @(posedge clk);
    check("badop_err", err_cnt - e0, 1);
    check("badop_score_held", score, 42);
    check("badop_no_write", exp_q.size(), 0);

    // Reset in the middle of FILL at address 100
    push_fill(8'h09);
    send_bits(32'h02000009, 32);
    n = 0;
    while (!(we && waddr == 10'd100) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reach_addr100", waddr, 100);
    resetB = 1'b0;
    #1;
    check("midfill_rst_we", we, 0);
    check("midfill_rst_busy", busy, 0);
    check("midfill_rst_score", score, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    resetB = 1'b1;
    repeat (700) @(posedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_no_write", exp_q.size(), 0);

    // Fresh frame after reset still works
    exp_q.push_back('{a: 10'h3FF, d: 8'hA5});
    send_bits(32'h0103FFA5, 32);
    wait_drain("post_rst_write_drain", 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
